te_filter_pipe: RTL
===================

// Module: te_filter_pipe
// PURPOSE
//  Pipelined, parametrised 3x3 edge-preserving filter for the transmission-estimate (TE) path.
//  Takes one 3x3 window per accepted beat and returns one filtered pixel.
//  Kernel is selected per frame by mode.
//  Sits between the line-buffer window generator and TE refinement; valid/ready on both sides.
// PARAMETERS
//  DATA_W   8  pixel width; internal sum width SUM_W = DATA_W+4
//  MODE_W   2  width of mode select (fixed encoding, see te_pkg)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         window beat valid
//  in_ready   out  1         window beat accepted when in_valid && in_ready
//  in_sof     in   1         first window of frame; qualifies mode latch
//  in_mode    in   MODE_W    kernel select, sampled only on accepted sof beat
//  in_win     in   9*DATA_W  window, in1 at LSBs .. in9 at MSBs, raster order
//  out_valid  out  1         result valid
//  out_ready  in   1         downstream accepts when out_valid && out_ready
//  out_sof    out  1         sof aligned with out_pix
//  out_pix    out  DATA_W    filtered pixel
// BEHAVIOUR
//  Modes:
//   0 BYPASS: in5
//   1 SMOOTH: [1 2 1;2 4 2;1 2 1] >>4
//   2 HORIZ:  (in4+2*in5+in6) >>2
//   3 VERT:   (in2+2*in5+in8) >>2
//  Mode register: reset 1 (SMOOTH). Loaded from in_mode on an accepted beat with in_sof=1.
//   That beat and all beats until the next accepted sof use the new mode; in_mode is ignored otherwise.
//   Each stage carries the mode bits of its own beat, so in-flight beats never change kernel.
//  Pipeline: 3 registered stages, latency 3 cycles accepted->out_valid when unstalled.
//   S1: three row partial sums (SUM_W) per mode; unused rows are zeroed.
//   S2: total sum, plus rounding term.
//   S3: shift by mode (4, 2 or 0), saturate to DATA_W, register out_pix.
//  Arithmetic: unsigned; all sums at SUM_W so 16*(2^DATA_W-1) never overflows.
//  Flow control: elastic.
//   Stage k loads when it is empty or stage k+1 loads that cycle; S3 drains when out_ready.
//   in_ready = !v1 || S1 advances (combinational from out_ready; no internal skid).
//   Throughput 1 beat/cycle with out_ready held high.
//   Full: 3 beats held while out_ready=0, then in_ready=0; no beat lost, duplicated or reordered.
//   Simultaneous drain+accept when full: both occur the same cycle.
//   out_pix/out_sof stable while out_valid && !out_ready.
//  Reset (async, any time incl. mid-frame): stage valids, out_valid, out_pix, out_sof -> 0; mode -> 1.
//   in_ready becomes 1 at reset deassertion; in-flight beats are discarded.
// CONFIGURATION
//  TE_ROUND_EN defined:
//   S2 adds half-LSB before the shift (8 for SMOOTH, 2 for HORIZ/VERT, 0 for BYPASS).
//   S3 saturates to 2^DATA_W-1.
//  TE_ROUND_EN undefined: truncating shift, no add; the saturate path is removed (cannot trigger).
// STRUCTURE
//  te_pkg:
//   mode localparams TE_BYPASS=0, TE_SMOOTH=1, TE_HORIZ=2, TE_VERT=3; TE_MODE_W=2
//   function sum_w(DATA_W)
//   per-mode shift and round constants
//  Sub-module te_row_sum:
//   weighted 1-2-1 sum of three pixels with row weight 1 or 2 and enable
//   instantiated 3x in S1; combinational
//  Top: stage registers, valid/ready chain, mode latch.
// TESTING
//  1 Mode1, all nine pixels 200, out_ready=1 -> out_pix 200 exactly 3 cycles after accept.
//  2 Mode1, in5=255, rest 0 -> 63 without TE_ROUND_EN, 64 with; all 255 -> 255 (no wrap) both builds.
//  3 Mode2: in4=10,in5=20,in6=30, others 255 -> 20.
//    Mode3: in2=10,in5=20,in8=31 -> 20 (trunc) / 20 (round: 83>>2).
//  4 Backpressure: stream 6 beats, out_ready=0 cycles 2-7.
//    in_ready=0 once 3 held; outputs in order, none lost; out_pix stable while stalled.
//  5 Mode change: sof beat mode2, then in_mode=3 without sof on following beats -> all beats mode2.
//    Next sof with mode3 switches from that beat; beats in flight keep their mode.
//  6 Assert rst_n low with 3 beats in flight -> out_valid=0 immediately; after release mode=1, no stale output.

Source files
------------

// File: rtl/te_pkg.sv
// Mode encoding and per-mode shift/round constants for the TE 3x3 edge-preserving filter.
// TE_ROUND_EN selects rounded (half-LSB added, saturated) versus truncating output.
package te_pkg;

    localparam int unsigned TE_MODE_W = 2;

    localparam logic [TE_MODE_W-1:0] TE_BYPASS = 2'd0;
    localparam logic [TE_MODE_W-1:0] TE_SMOOTH = 2'd1;
    localparam logic [TE_MODE_W-1:0] TE_HORIZ  = 2'd2;
    localparam logic [TE_MODE_W-1:0] TE_VERT   = 2'd3;

    // Four guard bits hold 16*(2^DATA_W-1) plus the largest rounding term.
    function automatic int unsigned sum_w(input int unsigned data_w);
        return data_w + 4;
    endfunction

    function automatic logic [2:0] mode_shift(input logic [TE_MODE_W-1:0] mode);
        case (mode)
            TE_SMOOTH: return 3'd4;
            TE_HORIZ:  return 3'd2;
            TE_VERT:   return 3'd2;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] mode_round(input logic [TE_MODE_W-1:0] mode);
        case (mode)
            TE_SMOOTH: return 4'd8;
            TE_HORIZ:  return 4'd2;
            TE_VERT:   return 4'd2;
            default:   return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/te_row_sum.sv
// One row of the 3x3 kernel: either left+2*mid+right or mid alone, optionally doubled,
// forced to zero when the row is unused by the current mode. Purely combinational.
module te_row_sum
    import te_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SUM_W  = sum_w(DATA_W)
) (
    input  logic [DATA_W-1:0] i_left,
    input  logic [DATA_W-1:0] i_mid,
    input  logic [DATA_W-1:0] i_right,
    input  logic              i_side_en,
    input  logic              i_dbl,
    input  logic              i_en,
    output logic [SUM_W-1:0]  o_sum
);

    logic [SUM_W-1:0] w_base;

    always_comb begin
        w_base = SUM_W'(i_mid);
        if (i_side_en) begin
            w_base = SUM_W'(i_left) + (SUM_W'(i_mid) << 1) + SUM_W'(i_right);
        end
        o_sum = '0;
        if (i_en) begin
            o_sum = i_dbl ? (w_base << 1) : w_base;
        end
    end

endmodule

// File: rtl/te_filter_pipe.sv
// Three-stage elastic 3x3 TE filter: row sums, total (+round), shift/saturate.
// Define TE_ROUND_EN for rounded, saturated output; otherwise the shift truncates.
module te_filter_pipe
    import te_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MODE_W = TE_MODE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sof,
    input  logic [MODE_W-1:0]   in_mode,
    input  logic [9*DATA_W-1:0] in_win,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sof,
    output logic [DATA_W-1:0]   out_pix
);

    localparam int unsigned SUM_W = sum_w(DATA_W);

    logic              w_ld1, w_ld2, w_ld3, w_acc;
    logic [MODE_W-1:0] w_mode_cur;
    logic [2:0]        w_en, w_side, w_dbl;
    logic [SUM_W-1:0]  w_row [3];
    logic [SUM_W-1:0]  w_sum2;
    logic [DATA_W-1:0] w_pix;

    logic              r_v1, r_v2, r_v3;
    logic              r_sof1, r_sof2, r_sof3;
    logic [MODE_W-1:0] r_mode, r_mode1, r_mode2;
    logic [SUM_W-1:0]  r_row1 [3];
    logic [SUM_W-1:0]  r_sum2;
    logic [DATA_W-1:0] r_pix3;

    // A stage takes new data when empty or when its successor takes its current beat.
    assign w_ld3    = !r_v3 || out_ready;
    assign w_ld2    = !r_v2 || w_ld3;
    assign w_ld1    = !r_v1 || w_ld2;
    assign in_ready = w_ld1;
    assign w_acc    = in_valid && w_ld1;

    // The sof beat itself already uses the newly selected kernel.
    assign w_mode_cur = (w_acc && in_sof) ? in_mode : r_mode;

    always_comb begin
        w_en   = 3'b000;
        w_side = 3'b000;
        w_dbl  = 3'b000;
        case (w_mode_cur)
            TE_BYPASS: w_en = 3'b010;
            TE_SMOOTH: begin
                w_en   = 3'b111;
                w_side = 3'b111;
                w_dbl  = 3'b010;
            end
            TE_HORIZ: begin
                w_en   = 3'b010;
                w_side = 3'b010;
            end
            TE_VERT: begin
                w_en  = 3'b111;
                w_dbl = 3'b010;
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < 3; g++) begin : g_row
        te_row_sum #(
            .DATA_W (DATA_W),
            .SUM_W  (SUM_W)
        ) u_row_sum (
            .i_left    (in_win[(3*g)*DATA_W +: DATA_W]),
            .i_mid     (in_win[(3*g+1)*DATA_W +: DATA_W]),
            .i_right   (in_win[(3*g+2)*DATA_W +: DATA_W]),
            .i_side_en (w_side[g]),
            .i_dbl     (w_dbl[g]),
            .i_en      (w_en[g]),
            .o_sum     (w_row[g])
        );
    end

`ifdef TE_ROUND_EN
    logic [SUM_W-1:0] w_shift;

    assign w_sum2  = r_row1[0] + r_row1[1] + r_row1[2] + SUM_W'(mode_round(r_mode1));
    assign w_shift = r_sum2 >> mode_shift(r_mode2);
    assign w_pix   = (w_shift > SUM_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : w_shift[DATA_W-1:0];
`else
    assign w_sum2 = r_row1[0] + r_row1[1] + r_row1[2];
    assign w_pix  = DATA_W'(r_sum2 >> mode_shift(r_mode2));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= TE_SMOOTH;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_sof1  <= 1'b0;
            r_sof2  <= 1'b0;
            r_sof3  <= 1'b0;
            r_mode1 <= TE_SMOOTH;
            r_mode2 <= TE_SMOOTH;
            r_row1  <= '{default: '0};
            r_sum2  <= '0;
            r_pix3  <= '0;
        end else begin
            if (w_acc && in_sof) begin
                r_mode <= in_mode;
            end
            if (w_ld1) begin
                r_v1    <= in_valid;
                r_sof1  <= in_valid && in_sof;
                r_mode1 <= w_mode_cur;
                r_row1  <= w_row;
            end
            if (w_ld2) begin
                r_v2    <= r_v1;
                r_sof2  <= r_sof1;
                r_mode2 <= r_mode1;
                r_sum2  <= w_sum2;
            end
            if (w_ld3) begin
                r_v3   <= r_v2;
                r_sof3 <= r_sof2;
                r_pix3 <= w_pix;
            end
        end
    end

    assign out_valid = r_v3;
    assign out_sof   = r_sof3;
    assign out_pix   = r_pix3;

endmodule
